// File: rtl/fpadd_pkg.sv
// Shared definitions for the fpadd sharing logic: scheduler states and
// the default width and latency of the floating-point adder.
package fpadd_pkg;

    localparam int FP_W      = 32;
    localparam int FPADD_LAT = 26;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/fpadd_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: the first requester after last_i
// (wrapping) that is asserted wins.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic            any_o,
    output logic [IDW-1:0]  grant_o,
    output logic [NREQ-1:0] onehot_o
);

    logic [IDW-1:0] idx;

    // Scan from the lowest priority down so the nearest candidate overwrites last.
    always_comb begin
        any_o    = 1'b0;
        grant_o  = '0;
        idx      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDW'((int'(last_i) + k) % NREQ);
            if (req_i[idx]) begin
                any_o   = 1'b1;
                grant_o = idx;
            end
        end
        onehot_o = any_o ? (NREQ'(1) << grant_o) : '0;
    end

endmodule

// File: rtl/fpadd_rr_scheduler.sv
// Shares one non-pipelined fpadd unit among NREQ requesters: round-robin
// accept, start pulse, minimum-latency wait, then a tagged response.
//
// state | meaning
// IDLE  | offer req_ready to the round-robin winner, latch its operands
// ISSUE | pulse fu_start, load the latency counter
// WAIT  | count down; capture fu_sum once the counter is 0 and fu_done is high
// RESP  | hold rsp_valid/rsp_sum/rsp_id until rsp_ready
module fpadd_rr_scheduler
    import fpadd_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = FP_W,
    parameter int LAT  = FPADD_LAT,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IDW-1:0]  rsp_id,
    output logic [W-1:0]    rsp_sum,
    output logic            fu_start,
    output logic [W-1:0]    fu_a,
    output logic [W-1:0]    fu_b,
    input  logic [W-1:0]    fu_sum,
    input  logic            fu_done,
    output logic            busy
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    state_e         state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] id_q, id_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   fu_a_q, fu_a_d;
    logic [W-1:0]   fu_b_q, fu_b_d;
    logic [W-1:0]   rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;

    logic            pick_any;
    logic [IDW-1:0]  pick_idx;
    logic [NREQ-1:0] pick_onehot;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i    (req_valid),
        .last_i   (last_q),
        .any_o    (pick_any),
        .grant_o  (pick_idx),
        .onehot_o (pick_onehot)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= IDW'(NREQ - 1);
            id_q      <= '0;
            cnt_q     <= '0;
            fu_a_q    <= '0;
            fu_b_q    <= '0;
            rsp_sum_q <= '0;
            rsp_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            fu_a_q    <= fu_a_d;
            fu_b_q    <= fu_b_d;
            rsp_sum_q <= rsp_sum_d;
            rsp_id_q  <= rsp_id_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        fu_a_d    = fu_a_q;
        fu_b_d    = fu_b_q;
        rsp_sum_d = rsp_sum_q;
        rsp_id_d  = rsp_id_q;
        req_ready = '0;
        fu_start  = 1'b0;
        rsp_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    req_ready = pick_onehot;
                    fu_a_d    = req_a[int'(pick_idx) * W +: W];
                    fu_b_d    = req_b[int'(pick_idx) * W +: W];
                    id_d      = pick_idx;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                fu_start = 1'b1;
                cnt_d    = CW'(LAT - 1);
                state_d  = WAIT;
            end
            WAIT: begin
                // An early fu_done is deliberately ignored until the counter expires.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (fu_done) begin
                    rsp_sum_d = fu_sum;
                    rsp_id_d  = id_q;
                    state_d   = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    last_d  = id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign fu_a    = fu_a_q;
    assign fu_b    = fu_b_q;
    assign rsp_sum = rsp_sum_q;
    assign rsp_id  = rsp_id_q;

endmodule

// File: tb/tb_fpadd_rr_scheduler.sv
// Bench for fpadd_rr_scheduler: stub adder unit with programmable done delay
// and a scoreboard of expected responses filled at each accept.
`timescale 1ns/1ps
module tb_fpadd_rr_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int LAT  = 26;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic              rsp_valid, rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              fu_start, fu_done, busy;
    logic [W-1:0]      fu_a, fu_b, fu_sum;

    always #5 clk = ~clk;

    fpadd_rr_scheduler #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .fu_start(fu_start), .fu_a(fu_a), .fu_b(fu_b),
        .fu_sum(fu_sum), .fu_done(fu_done), .busy(busy)
    );

    // Stub adder: done rises stub_d cycles after the edge that samples fu_start.
    int   stub_d = 5;
    int   s_cnt;
    logic s_active;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            s_active <= 1'b0;
            s_cnt    <= 0;
        end else if (fu_start) begin
            s_active <= 1'b1;
            s_cnt    <= 0;
        end else if (s_active && s_cnt < 1000) begin
            s_cnt <= s_cnt + 1;
        end
    end
    assign fu_done = s_active && (s_cnt >= stub_d);
    assign fu_sum  = fu_a + fu_b;

    typedef struct {
        int          id;
        logic [W-1:0] sum;
        int          acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_acc = 0;
    int   n_start = 0;
    int   start_cyc = 0;
    int   passed = 0;
    int   total = 0;
    logic [W-1:0] mon_sum;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mon_sum = req_a[i*W +: W] + req_b[i*W +: W];
                    exp_q.push_back('{id: i, sum: mon_sum, acc_cyc: cyc});
                    n_acc++;
                end
            end
            if (fu_start) begin
                n_start++;
                start_cyc = cyc;
            end
        end
    end

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            sample();
            if (n_acc >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rsp(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            sample();
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0; stub_d = 5;
        reset = 1'b1;
        repeat (3) sample();
        total++; if (req_ready !== '0) $display("FAIL reset_req_ready got=%h exp=0", req_ready); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else passed++;
        total++; if (rsp_id !== '0) $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); else passed++;
        total++; if (rsp_sum !== '0) $display("FAIL reset_rsp_sum got=%h exp=0", rsp_sum); else passed++;
        total++; if (fu_start !== 1'b0) $display("FAIL reset_fu_start got=%b exp=0", fu_start); else passed++;
        total++; if (fu_a !== '0) $display("FAIL reset_fu_a got=%h exp=0", fu_a); else passed++;
        total++; if (fu_b !== '0) $display("FAIL reset_fu_b got=%h exp=0", fu_b); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        at_pos();
        reset = 1'b0;
    endtask

    task automatic test_single();
        bit   ok;
        int   tgt, s0;
        exp_t e;
        stub_d = 5; rsp_ready = 1'b1;
        at_pos();
        req_a[0 +: W] = 32'h3F80_0000;
        req_b[0 +: W] = 32'h4000_0000;
        req_valid = 4'b0001;
        tgt = n_acc + 1; s0 = n_start;
        wait_acc(tgt, 10, ok);
        total++; if (!ok) begin $display("FAIL single_accept timed out got=none exp=accept"); return; end else passed++;
        at_pos();
        req_valid = '0;
        req_a[0 +: W] = 32'hDEAD_BEEF;
        sample();
        total++; if (fu_start !== 1'b1) $display("FAIL single_fu_start got=%b exp=1", fu_start); else passed++;
        total++; if (fu_a !== 32'h3F80_0000) $display("FAIL single_fu_a got=%h exp=3f800000", fu_a); else passed++;
        total++; if (fu_b !== 32'h4000_0000) $display("FAIL single_fu_b got=%h exp=40000000", fu_b); else passed++;
        wait_rsp(60, ok);
        total++; if (!ok) begin $display("FAIL single_rsp timed out got=none exp=rsp_valid"); return; end else passed++;
        total++;
        if (exp_q.size() == 0) begin $display("FAIL single_sb got=rsp exp=empty queue"); return; end else passed++;
        e = exp_q.pop_front();
        total++; if (cyc - e.acc_cyc != LAT + 2) $display("FAIL single_latency got=%0d exp=%0d", cyc - e.acc_cyc, LAT + 2); else passed++;
        total++; if (rsp_id !== IDW'(e.id)) $display("FAIL single_rsp_id got=%0d exp=%0d", rsp_id, e.id); else passed++;
        total++; if (rsp_sum !== 32'h7F80_0000) $display("FAIL single_rsp_sum got=%h exp=7f800000", rsp_sum); else passed++;
        total++; if (n_start - s0 != 1) $display("FAIL single_start_count got=%0d exp=1", n_start - s0); else passed++;
        at_pos();
        sample();
        total++; if (busy !== 1'b0) $display("FAIL single_busy_after got=%b exp=0", busy); else passed++;
    endtask

    task automatic test_round_robin();
        bit   ok;
        int   s0;
        exp_t e;
        int   order[5] = '{0, 1, 2, 3, 0};
        at_pos(); reset = 1'b1;
        sample();
        at_pos(); reset = 1'b0;
        stub_d = 5; rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = 32'h0100_0000 * (i + 1);
            req_b[i*W +: W] = 32'h0000_1111 * (i + 3);
        end
        s0 = n_start;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(80, ok);
            total++; if (!ok) begin $display("FAIL rr_rsp%0d timed out got=none exp=rsp_valid", k); req_valid = '0; return; end else passed++;
            total++;
            if (exp_q.size() == 0) begin $display("FAIL rr_sb%0d got=rsp exp=empty queue", k); req_valid = '0; return; end else passed++;
            e = exp_q.pop_front();
            total++; if (rsp_id !== IDW'(order[k])) $display("FAIL rr_grant%0d got=%0d exp=%0d", k, rsp_id, order[k]); else passed++;
            total++; if (rsp_sum !== e.sum) $display("FAIL rr_sum%0d got=%h exp=%h", k, rsp_sum, e.sum); else passed++;
            at_pos();
            req_a[e.id*W +: W] = $urandom;
            req_b[e.id*W +: W] = $urandom;
            if (k == 4) req_valid = '0;
        end
        sample();
        total++; if (n_start - s0 != 5) $display("FAIL rr_start_count got=%0d exp=5", n_start - s0); else passed++;
        total++; if (exp_q.size() != 0) $display("FAIL rr_extra_accept got=%0d exp=0", exp_q.size()); else passed++;
    endtask

    task automatic test_hold();
        bit           ok;
        int           tgt, s0;
        exp_t         e;
        logic [W-1:0] h_sum;
        logic [IDW-1:0] h_id;
        stub_d = 5; rsp_ready = 1'b0;
        at_pos();
        req_a[2*W +: W] = 32'h1234_0000;
        req_b[2*W +: W] = 32'h0000_5678;
        req_valid = 4'b0100;
        tgt = n_acc + 1;
        wait_acc(tgt, 10, ok);
        total++; if (!ok) begin $display("FAIL hold_accept timed out got=none exp=accept"); req_valid = '0; return; end else passed++;
        at_pos();
        req_valid = 4'b1111;
        wait_rsp(60, ok);
        total++; if (!ok) begin $display("FAIL hold_rsp timed out got=none exp=rsp_valid"); req_valid = '0; return; end else passed++;
        e = exp_q.pop_front();
        total++; if (rsp_id !== 2'd2) $display("FAIL hold_rsp_id got=%0d exp=2", rsp_id); else passed++;
        total++; if (rsp_sum !== e.sum) $display("FAIL hold_rsp_sum got=%h exp=%h", rsp_sum, e.sum); else passed++;
        h_sum = e.sum; h_id = 2'd2; s0 = n_start;
        for (int k = 0; k < 10; k++) begin
            sample();
            total++; if (rsp_valid !== 1'b1) $display("FAIL hold_valid%0d got=%b exp=1", k, rsp_valid); else passed++;
            total++; if (rsp_sum !== h_sum) $display("FAIL hold_sum%0d got=%h exp=%h", k, rsp_sum, h_sum); else passed++;
            total++; if (rsp_id !== h_id) $display("FAIL hold_id%0d got=%0d exp=%0d", k, rsp_id, h_id); else passed++;
            total++; if (req_ready !== '0) $display("FAIL hold_req_ready%0d got=%h exp=0", k, req_ready); else passed++;
        end
        total++; if (n_start != s0) $display("FAIL hold_no_start got=%0d exp=0", n_start - s0); else passed++;
        at_pos();
        rsp_ready = 1'b1;
        req_valid = '0;
        at_pos();
        sample();
        total++; if (busy !== 1'b0) $display("FAIL hold_release got=%b exp=0", busy); else passed++;
    endtask

    task automatic test_done_timing(input int d, input int req, input int exp_lat, input string nm);
        bit   ok;
        int   tgt;
        exp_t e;
        stub_d = d; rsp_ready = 1'b1;
        at_pos();
        req_a[req*W +: W] = $urandom;
        req_b[req*W +: W] = $urandom;
        req_valid = '0;
        req_valid[req] = 1'b1;
        tgt = n_acc + 1;
        wait_acc(tgt, 10, ok);
        total++; if (!ok) begin $display("FAIL %s_accept timed out got=none exp=accept", nm); req_valid = '0; return; end else passed++;
        at_pos();
        req_valid = '0;
        wait_rsp(120, ok);
        total++; if (!ok) begin $display("FAIL %s_rsp timed out got=none exp=rsp_valid", nm); return; end else passed++;
        e = exp_q.pop_front();
        total++; if (cyc - start_cyc != exp_lat) $display("FAIL %s_latency got=%0d exp=%0d", nm, cyc - start_cyc, exp_lat); else passed++;
        total++; if (rsp_id !== IDW'(req)) $display("FAIL %s_rsp_id got=%0d exp=%0d", nm, rsp_id, req); else passed++;
        total++; if (rsp_sum !== e.sum) $display("FAIL %s_rsp_sum got=%h exp=%h", nm, rsp_sum, e.sum); else passed++;
        at_pos();
        sample();
    endtask

    task automatic test_reset_mid_wait();
        bit   ok;
        int   tgt, seen_rv, s0;
        exp_t e;
        test_done_timing(5, 1, LAT + 1, "pre_reset");
        stub_d = 5; rsp_ready = 1'b1;
        at_pos();
        req_a[2*W +: W] = 32'h0000_0AAA;
        req_b[2*W +: W] = 32'h0000_0555;
        req_valid = 4'b0100;
        tgt = n_acc + 1;
        wait_acc(tgt, 10, ok);
        total++; if (!ok) begin $display("FAIL mid_accept timed out got=none exp=accept"); req_valid = '0; return; end else passed++;
        at_pos();
        req_valid = '0;
        repeat (10) sample();
        total++; if (busy !== 1'b1) $display("FAIL mid_busy_before got=%b exp=1", busy); else passed++;
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL mid_busy got=%b exp=0", busy); else passed++;
        total++; if (fu_a !== '0) $display("FAIL mid_fu_a got=%h exp=0", fu_a); else passed++;
        total++; if (fu_b !== '0) $display("FAIL mid_fu_b got=%h exp=0", fu_b); else passed++;
        total++; if (rsp_sum !== '0) $display("FAIL mid_rsp_sum got=%h exp=0", rsp_sum); else passed++;
        total++; if (rsp_id !== '0) $display("FAIL mid_rsp_id got=%0d exp=0", rsp_id); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL mid_rsp_valid got=%b exp=0", rsp_valid); else passed++;
        sample();
        at_pos();
        reset = 1'b0;
        seen_rv = 0; s0 = n_start;
        for (int k = 0; k < 40; k++) begin
            sample();
            if (rsp_valid) seen_rv++;
        end
        total++; if (seen_rv != 0) $display("FAIL mid_no_rsp got=%0d exp=0", seen_rv); else passed++;
        total++; if (n_start != s0) $display("FAIL mid_no_start got=%0d exp=0", n_start - s0); else passed++;
        at_pos();
        req_valid = 4'b1111;
        tgt = n_acc + 1;
        wait_acc(tgt, 10, ok);
        total++; if (!ok) begin $display("FAIL post_accept timed out got=none exp=accept"); req_valid = '0; return; end else passed++;
        at_pos();
        req_valid = '0;
        wait_rsp(60, ok);
        total++; if (!ok) begin $display("FAIL post_rsp timed out got=none exp=rsp_valid"); return; end else passed++;
        e = exp_q.pop_front();
        total++; if (rsp_id !== 2'd0) $display("FAIL post_grant got=%0d exp=0", rsp_id); else passed++;
        total++; if (rsp_sum !== e.sum) $display("FAIL post_sum got=%h exp=%h", rsp_sum, e.sum); else passed++;
        at_pos();
        sample();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_done_timing(40, 1, 42, "late_done");
        test_done_timing(1, 3, LAT + 1, "early_done");
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
